// File: rtl/fifo_ctrl.sv
// Pointer/status controller for a DEPTH-entry FIFO storage array; optional FIFO_CTRL_ERR_FLAG_EN adds sticky overflow/underflow.
// Latency: wr_en is combinational with the push; pointers, count and flags update on the same edge (storage read data follows 1 cycle later).
// Backpressure: pushes while full and pops while empty are rejected without touching pointers or count.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_CTRL_ERR_FLAG_EN
    ,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int                CW      = ADDR_WIDTH + 1;
    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]     AE_C    = CW'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance uses the registered flags, so a simultaneous push/pop on a
    // full FIFO only pops and on an empty FIFO only pushes.
    always_comb begin
        push_ok = wr & ~full_q;
        pop_ok  = rd & ~empty_q;
        w_ptr_d = w_ptr_q + ADDR_WIDTH'(push_ok);
        r_ptr_d = r_ptr_q + ADDR_WIDTH'(pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    // full_q is cleared by reset, so the write enable needs an explicit reset gate.
    assign wr_en        = push_ok & reset_n;
    assign w_addr       = w_ptr_q;
    assign r_addr       = r_ptr_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A new error event takes priority over a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr && full_q) begin
            ovf_d = 1'b1;
        end
        if (rd && empty_q) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule
